sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//   Downstream stage of the 8-bit sequential adder. Consumes the adder's 9-bit registered sum
//   and aligns it to a caller-supplied issue strobe using a LAT-deep valid delay line.
//   Accumulates N_SAMPLES aligned sums into an ACC_W-bit total.
//   Presents each total on a valid/ready output handshake with sticky overflow/drop flags.
// PARAMETERS
//   IN_W       9   width of adder sum input
//   ACC_W      16  accumulator/result width (ACC_W > IN_W)
//   N_SAMPLES  4   sums per frame (>=1)
//   LAT        3   adder latency, operands-presented -> sum-on-output, in cycles (>=1)
// PORTS
//   clk          in   1                  clock; all logic on posedge
//   rst_n        in   1                  synchronous reset, active-low
//   issue        in   1                  operands presented to adder this cycle
//   sum_in       in   IN_W               adder sum output
//   clear        in   1                  synchronous frame abort
//   acc_out      out  ACC_W              frame total
//   acc_valid    out  1                  acc_out/overflow/dropped valid
//   acc_ready    in   1                  consumer accepts when acc_valid&acc_ready
//   overflow     out  1                  frame total wrapped past 2^ACC_W
//   dropped      out  1                  >=1 aligned sum discarded while holding the previous frame
//   busy         out  1                  state != IDLE
//   sample_cnt   out  $clog2(N_SAMPLES+1) sums accumulated in current frame
// BEHAVIOUR
//   Reset (rst_n=0 at posedge)
//     - All outputs 0; delay line 0; state IDLE. Reset overrides everything.
//   Alignment
//     - vld_d[0] <= issue; vld_d[k] <= vld_d[k-1].
//     - Aligned strobe s = vld_d[LAT-1].
//     - sum_in is sampled on the cycle s=1; sum_in is ignored when s=0.
//   FSM: IDLE, ACCUM, HOLD
//     - IDLE, s=1: acc <= zero-ext sum_in, cnt <= 1; go to ACCUM (HOLD if N_SAMPLES==1).
//     - ACCUM, s=1: acc <= acc + sum_in (mod 2^ACC_W), cnt++. A carry out of bit ACC_W-1 sets the overflow latch.
//       Go to HOLD when the new cnt == N_SAMPLES.
//     - HOLD: acc_valid=1. acc_out/overflow/dropped/sample_cnt stay stable until handshake.
//       * acc_ready=1, s=0: go to IDLE. acc_valid, overflow, dropped, cnt -> 0 next cycle. acc_out keeps its last value.
//       * acc_ready=1, s=1: the sum starts a new frame (acc=sum_in, cnt=1, ACCUM or HOLD per N_SAMPLES).
//         New frame flags start at 0; no loss.
//       * acc_ready=0, s=1: the sum is discarded and the dropped latch is set (sticky for this frame).
//   Latency
//     - issue of the last operand pair -> acc_valid=1: LAT+1 cycles.
//   Clear (rst_n=1, clear=1)
//     - state IDLE; acc, cnt, flags, acc_valid -> 0.
//     - Delay line is kept, so issues in flight still land.
//     - A sum with s=1 in the same cycle is discarded; dropped is not set.
//   Output rules
//     - acc_valid is registered and never depends combinationally on acc_ready.
//     - issue is allowed every cycle. Back-to-back frames sustain 1 sum/cycle when acc_ready=1.
// TESTING
//   1. Reset, N=4, LAT=3: issue for 4 cycles with sums 10,20,30,40 arriving at t+3
//      -> acc_out=100, acc_valid=1 at cycle 4 after the last issue.
//   2. Hold test: acc_ready=0 for 5 cycles with 2 more sums arriving -> acc_out stays 100, dropped=1.
//      Then acc_ready=1 -> next cycle acc_valid=0, busy=0.
//   3. ACC_W=10, sums 511,511,511: total 1533 -> acc_out=509, overflow=1.
//      Next frame of 1,1,1,1 -> overflow=0.
//   4. Continuous issue, acc_ready tied 1, 8 sums of 5 -> two frames of 20, no gap, dropped=0.
//   5. clear after 2 of 4 sums (15,15) -> busy=0 next cycle.
//      The next 4 sums of 1 -> acc_out=4, not 34.
//   6. rst_n=0 mid-ACCUM and while acc_valid=1 -> all outputs 0 next cycle.
//      Issues from before reset never produce a sample.

Source files
------------

// File: rtl/sum_accumulator.sv
// Aligns the adder's registered sum to its issue strobe via a LAT-deep valid delay line,
// accumulates N_SAMPLES aligned sums per frame and holds each total on a valid/ready output.
module sum_accumulator #(
    parameter int IN_W      = 9,
    parameter int ACC_W     = 16,
    parameter int N_SAMPLES = 4,
    parameter int LAT       = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               issue,
    input  logic [IN_W-1:0]                    sum_in,
    input  logic                               clear,
    output logic [ACC_W-1:0]                   acc_out,
    output logic                               acc_valid,
    input  logic                               acc_ready,
    output logic                               overflow,
    output logic                               dropped,
    output logic                               busy,
    output logic [$clog2(N_SAMPLES+1)-1:0]     sample_cnt
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SAMPLES);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state;
    logic [LAT-1:0]     vld_d;
    logic               s;
    logic               start;
    logic [ACC_W-1:0]   sum_ext;
    logic [ACC_W:0]     acc_sum;
    logic [CNT_W-1:0]   cnt_inc;

    assign s       = vld_d[LAT-1];
    assign sum_ext = {{(ACC_W-IN_W){1'b0}}, sum_in};
    assign acc_sum = {1'b0, acc_out} + {1'b0, sum_ext};
    assign cnt_inc = sample_cnt + 1'b1;

    // A fresh frame begins from IDLE, or straight out of HOLD when the consumer takes the total
    // in the same cycle a sum lands, which keeps back-to-back frames gap-free.
    assign start = s && ((state == IDLE) || ((state == HOLD) && acc_ready));

    assign acc_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vld_d      <= '0;
            acc_out    <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            vld_d[0] <= issue;
            for (int k = 1; k < LAT; k++) begin
                vld_d[k] <= vld_d[k-1];
            end

            // Clear leaves the delay line alone so issues already in flight still land.
            if (clear) begin
                state      <= IDLE;
                acc_out    <= '0;
                sample_cnt <= '0;
                overflow   <= 1'b0;
                dropped    <= 1'b0;
            end else if (start) begin
                acc_out    <= sum_ext;
                sample_cnt <= CNT_W'(1);
                overflow   <= 1'b0;
                dropped    <= 1'b0;
                state      <= (N_SAMPLES == 1) ? HOLD : ACCUM;
            end else begin
                case (state)
                    ACCUM: begin
                        if (s) begin
                            acc_out    <= acc_sum[ACC_W-1:0];
                            sample_cnt <= cnt_inc;
                            if (acc_sum[ACC_W]) begin
                                overflow <= 1'b1;
                            end
                            state <= (cnt_inc == N_CNT) ? HOLD : ACCUM;
                        end
                    end
                    HOLD: begin
                        if (acc_ready) begin
                            state      <= IDLE;
                            sample_cnt <= '0;
                            overflow   <= 1'b0;
                            dropped    <= 1'b0;
                        end else if (s) begin
                            dropped <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Drives a 16-bit and a 10-bit accumulator with identical directed stimulus and checks both
// every cycle against an integer-total frame model, plus hand-computed expectations.
module tb_sum_accumulator;

    localparam int LAT = 3;
    localparam int N   = 4;

    logic       clk = 1'b0;
    logic       rst_n, issue, clear, acc_ready;
    logic [8:0] sum_in;

    logic [15:0] acc16;
    logic [9:0]  acc10;
    logic        v16, v10, o16, o10, d16, d10, b16, b10;
    logic [2:0]  c16, c10;

    sum_accumulator #(.IN_W(9), .ACC_W(16), .N_SAMPLES(N), .LAT(LAT)) dut16 (
        .clk(clk), .rst_n(rst_n), .issue(issue), .sum_in(sum_in), .clear(clear),
        .acc_out(acc16), .acc_valid(v16), .acc_ready(acc_ready), .overflow(o16),
        .dropped(d16), .busy(b16), .sample_cnt(c16)
    );

    sum_accumulator #(.IN_W(9), .ACC_W(10), .N_SAMPLES(N), .LAT(LAT)) dut10 (
        .clk(clk), .rst_n(rst_n), .issue(issue), .sum_in(sum_in), .clear(clear),
        .acc_out(acc10), .acc_valid(v10), .acc_ready(acc_ready), .overflow(o10),
        .dropped(d10), .busy(b10), .sample_cnt(c10)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int sched [4096];
    int land_q [$];

    // Model: true (unbounded) frame total; DUT outputs are that total reduced mod 2^ACC_W.
    int m_total, m_cnt;
    bit m_hold, m_drop, m_ovf;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    task automatic new_frame(input int v);
        m_total = v;
        m_cnt   = 1;
        m_drop  = 0;
        m_ovf   = 1;
        m_hold  = (N == 1);
    endtask

    task automatic model_edge();
        bit s;
        if (!rst_n) begin
            land_q.delete();
            m_total = 0; m_cnt = 0; m_hold = 0; m_drop = 0; m_ovf = 0;
            return;
        end
        s = 0;
        if (land_q.size() > 0 && land_q[0] == cyc) begin
            s = 1;
            void'(land_q.pop_front());
        end
        if (issue) land_q.push_back(cyc + LAT);
        if (clear) begin
            m_total = 0; m_cnt = 0; m_hold = 0; m_drop = 0; m_ovf = 0;
        end else if (m_hold) begin
            if (acc_ready) begin
                if (s) new_frame(int'(sum_in));
                else begin
                    m_hold = 0; m_cnt = 0; m_drop = 0; m_ovf = 0;
                end
            end else if (s) begin
                m_drop = 1;
            end
        end else if (s) begin
            if (m_cnt == 0) new_frame(int'(sum_in));
            else begin
                m_total += int'(sum_in);
                m_cnt++;
                if (m_cnt == N) m_hold = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("acc16",   acc16, m_total % 65536);
        chk("ovf16",   o16,   (m_ovf && m_total >= 65536) ? 1 : 0);
        chk("acc10",   acc10, m_total % 1024);
        chk("ovf10",   o10,   (m_ovf && m_total >= 1024) ? 1 : 0);
        chk("valid16", v16,   m_hold);
        chk("valid10", v10,   m_hold);
        chk("drop16",  d16,   m_drop);
        chk("drop10",  d10,   m_drop);
        chk("busy16",  b16,   (m_cnt != 0) ? 1 : 0);
        chk("busy10",  b10,   (m_cnt != 0) ? 1 : 0);
        chk("cnt16",   c16,   m_cnt);
        chk("cnt10",   c10,   m_cnt);
    endtask

    // One clock: apply inputs, advance model to the coming edge, then check just after it.
    task automatic step(input bit iss, input int val, input bit rdy, input bit clr, input bit rn);
        cyc++;
        rst_n     = rn;
        issue     = iss;
        acc_ready = rdy;
        clear     = clr;
        if (iss) sched[cyc + LAT] = val;
        if (sched[cyc] >= 0) sum_in = 9'(sched[cyc]);
        else                 sum_in = 9'($urandom_range(511, 0));
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, rdy, 0, 1);
    endtask

    initial begin
        int nv;
        for (int i = 0; i < 4096; i++) sched[i] = -1;
        rst_n = 0; issue = 0; clear = 0; acc_ready = 0; sum_in = '0;

        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_valid", v16, 0);
        chk("rst_acc",   acc16, 0);
        chk("rst_busy",  b16, 0);
        chk("rst_cnt",   c16, 0);

        // Frame 10+20+30+40, valid appears LAT+1 cycles after the last issue.
        step(1, 10, 0, 0, 1);
        step(1, 20, 0, 0, 1);
        step(1, 30, 0, 0, 1);
        step(1, 40, 0, 0, 1);
        idle(2, 0);
        chk("t1_not_yet", v16, 0);
        idle(1, 0);
        chk("t1_valid", v16, 1);
        chk("t1_acc",   acc16, 100);

        // Two sums land while held: total stays, dropped latches.
        step(1, 7, 0, 0, 1);
        step(1, 8, 0, 0, 1);
        idle(3, 0);
        chk("t2_acc",   acc16, 100);
        chk("t2_drop",  d16, 1);
        chk("t2_valid", v16, 1);
        idle(1, 1);
        chk("t2_valid_off", v16, 0);
        chk("t2_busy_off",  b16, 0);
        chk("t2_acc_kept",  acc16, 100);
        chk("t2_drop_off",  d16, 0);

        // Wrap in the 10-bit instance: 1533 mod 1024 = 509.
        step(1, 511, 0, 0, 1);
        step(1, 511, 0, 0, 1);
        step(1, 511, 0, 0, 1);
        step(1, 0,   0, 0, 1);
        idle(3, 0);
        chk("t3_acc10", acc10, 509);
        chk("t3_ovf10", o10, 1);
        chk("t3_acc16", acc16, 1533);
        chk("t3_ovf16", o16, 0);
        idle(1, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 1);
        idle(3, 1);
        chk("t3b_valid", v10, 1);
        chk("t3b_acc10", acc10, 4);
        chk("t3b_ovf10", o10, 0);
        idle(1, 1);

        // Continuous issue with ready tied high: two frames of 20, back to back.
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            step(i < 8, 5, 1, 0, 1);
            if (v16) begin
                nv++;
                chk("t4_frame", acc16, 20);
                chk("t4_drop",  d16, 0);
            end
        end
        chk("t4_nframes", nv, 2);

        // Abort after two sums, then a fresh frame of ones.
        step(1, 15, 1, 0, 1);
        step(1, 15, 1, 0, 1);
        idle(3, 1);
        chk("t5_cnt_pre", c16, 2);
        step(0, 0, 1, 1, 1);
        chk("t5_busy", b16, 0);
        chk("t5_acc",  acc16, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
        idle(3, 0);
        chk("t5_acc_new", acc16, 4);
        chk("t5_valid",   v16, 1);
        idle(1, 1);

        // Issue landing in the same cycle as clear is discarded without setting dropped.
        step(1, 9, 0, 0, 1);
        idle(2, 0);
        step(0, 0, 0, 1, 1);
        chk("t5c_busy", b16, 0);
        chk("t5c_drop", d16, 0);
        // In-flight issue survives a clear.
        step(1, 6, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        idle(2, 0);
        chk("t5d_cnt", c16, 1);
        chk("t5d_acc", acc16, 6);
        step(0, 0, 0, 1, 1);

        // Reset mid-frame with one issue in flight.
        step(1, 2, 0, 0, 1);
        step(1, 2, 0, 0, 1);
        step(1, 2, 0, 0, 1);
        idle(2, 0);
        chk("t6_cnt_pre", c16, 2);
        step(0, 0, 0, 0, 0);
        chk("t6_acc",  acc16, 0);
        chk("t6_busy", b16, 0);
        chk("t6_cnt",  c16, 0);
        idle(4, 0);
        chk("t6_no_ghost", b16, 0);

        // Reset while a total is being presented.
        for (int i = 0; i < 4; i++) step(1, 3, 0, 0, 1);
        idle(3, 0);
        chk("t6b_valid_pre", v16, 1);
        step(0, 0, 0, 0, 0);
        chk("t6b_valid", v16, 0);
        chk("t6b_acc",   acc16, 0);
        chk("t6b_ovf",   o10, 0);
        idle(3, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
